mem_readback: RTL
=================

MEM_READBACK -- requirements
Module: mem_readback

Interface
REQ-001 SHALL have parameter WID_MEM, default 18, memory word width in bits.
REQ-002 SHALL have parameter DEPTH_MEM, default 2048, number of words read per pass (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request one full readback pass.
REQ-006 SHALL have port busy  output  1  pass in progress.
REQ-007 SHALL have port done  output  1  one-cycle pulse at pass completion.
REQ-008 SHALL have port mem_raddr  output  32  read address to memory read port.
REQ-009 SHALL have port mem_dout  input  WID_MEM  memory read data, registered in memory, valid the cycle after mem_raddr is sampled.
REQ-010 SHALL have port rd_data  output  WID_MEM  streamed word.
REQ-011 SHALL have port rd_valid  output  1  rd_data valid.
REQ-012 SHALL have port rd_ready  input  1  consumer accepts; beat transfers when rd_valid&&rd_ready.
REQ-013 SHALL have port rd_last  output  1  marks word at address DEPTH_MEM-1.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN; IDLE->RUN when start sampled high in IDLE.
REQ-015 SHALL ignore start while in RUN or DRAIN.
REQ-016 In RUN SHALL issue reads at addresses 0..DEPTH_MEM-1 ascending, at most one per cycle, no wrap; mem_raddr holds last issued address while stalled.
REQ-017 SHALL move RUN->DRAIN in the cycle after issuing address DEPTH_MEM-1.
REQ-018 SHALL capture mem_dout into a 3-entry output FIFO exactly two cycles after the corresponding address is driven (one memory cycle plus one capture edge).
REQ-019 SHALL issue a new read only when (FIFO occupancy + reads in flight) < 3; FIFO SHALL never overflow; rd_ready SHALL NOT combinationally affect mem_raddr.
REQ-020 With start high in cycle N and rd_ready held high, mem_raddr=0 in cycle N+1, first rd_valid in cycle N+3, then one beat per cycle with no bubbles.
REQ-021 rd_valid SHALL stay high and rd_data/rd_last stable until the beat is accepted.
REQ-022 rd_last SHALL be high only on the beat carrying address DEPTH_MEM-1; DEPTH_MEM=1 gives a single beat with rd_last=1.
REQ-023 DRAIN->IDLE in the cycle after the rd_last beat is accepted; done SHALL pulse high for exactly that one cycle.
REQ-024 busy SHALL be high in RUN and DRAIN, low in IDLE.
REQ-025 In IDLE mem_raddr SHALL be 0, rd_valid and rd_last 0.

Reset
REQ-026 On reset sampled high: state IDLE, busy=0, done=0, rd_valid=0, rd_last=0, rd_data=0, mem_raddr=0, FIFO and in-flight tracking cleared.
REQ-027 Reset mid-pass SHALL abort the pass, discard in-flight data, emit no done; memory contents are not touched (read-only block).
REQ-028 reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 With macro MEM_READBACK_CHECKSUM_EN defined, SHALL add output checksum (32 bits): sum mod 2^32 of zero-extended accepted rd_data words, cleared to 0 on the start of each pass and on reset, final value stable from the done pulse until the next start.
REQ-030 Without MEM_READBACK_CHECKSUM_EN, the checksum port and logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 Memory init word[i]=i (18-bit, 2048 deep), rd_ready=1, start pulse in cycle N -> rd_valid from N+3, data 0..2047 in consecutive cycles, rd_last on 2047, done one cycle after that beat; checksum=0x1FFC00 when enabled.
REQ-032 Same init, rd_ready toggling 1,0,1,0 -> identical data sequence, no lost or duplicated words, mem_raddr never more than 3 ahead of last accepted address.
REQ-033 rd_ready=0 for 20 cycles after start -> exactly 3 reads issued, rd_valid held with rd_data=0; on release, stream resumes 0,1,2,3...
REQ-034 Reset asserted after 100 accepted beats -> next cycle rd_valid=0, busy=0, no done; new start streams again from address 0 (checksum restarts at 0).
REQ-035 start re-pulsed during RUN -> ignored, exactly 2048 beats and one done; DEPTH_MEM=1, word[0]=0x3FFFF -> single beat 0x3FFFF with rd_last=1, done next cycle.

Source files
------------

// File: rtl/mem_readback.sv
// Streams DEPTH_MEM words from a registered-read memory through a 3-entry FIFO with valid/ready.
// Optional running checksum of accepted words when MEM_READBACK_CHECKSUM_EN is defined.
module mem_readback #(
    parameter int WID_MEM   = 18,
    parameter int DEPTH_MEM = 2048
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [31:0]        mem_raddr,
    input  logic [WID_MEM-1:0] mem_dout,
    output logic [WID_MEM-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               rd_last
`ifdef MEM_READBACK_CHECKSUM_EN
    ,
    output logic [31:0]        checksum
`endif
);

    localparam logic [31:0] LAST_ADDR = 32'(DEPTH_MEM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state;

    // rd_pend: mem_raddr carries a new read this cycle; cap_pend: mem_dout holds its data.
    logic rd_pend, rd_pend_last;
    logic cap_pend, cap_pend_last;

    logic [2:0]         fifo_v;
    logic [2:0]         fifo_l;
    logic [WID_MEM-1:0] fifo_d [3];

    logic [2:0]         nxt_v;
    logic [2:0]         nxt_l;
    logic [WID_MEM-1:0] nxt_d [3];
    logic               placed;

    logic               pop;
    logic [1:0]         fifo_occ;
    logic [2:0]         committed;
    logic               can_issue;

    assign rd_valid = fifo_v[0];
    assign rd_data  = fifo_d[0];
    assign rd_last  = fifo_l[0];
    assign pop      = fifo_v[0] & rd_ready;

    // Slots already spoken for after this edge; a new read only fits if one is left.
    assign fifo_occ  = 2'(fifo_v[0]) + 2'(fifo_v[1]) + 2'(fifo_v[2]);
    assign committed = 3'(fifo_occ) - 3'(pop) + 3'(rd_pend) + 3'(cap_pend);
    assign can_issue = committed < 3'd3;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned (no latch).
        nxt_v  = fifo_v;
        nxt_l  = fifo_l;
        nxt_d  = fifo_d;
        placed = 1'b0;
        if (pop) begin
            nxt_v    = {1'b0, fifo_v[2:1]};
            nxt_l    = {1'b0, fifo_l[2:1]};
            nxt_d[0] = fifo_d[1];
            nxt_d[1] = fifo_d[2];
        end
        if (cap_pend) begin
            for (int i = 0; i < 3; i++) begin
                if (!placed && !nxt_v[i]) begin
                    nxt_v[i] = 1'b1;
                    nxt_l[i] = cap_pend_last;
                    nxt_d[i] = mem_dout;
                    placed   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem_raddr     <= '0;
            rd_pend       <= 1'b0;
            rd_pend_last  <= 1'b0;
            cap_pend      <= 1'b0;
            cap_pend_last <= 1'b0;
            fifo_v        <= '0;
            fifo_l        <= '0;
            // NOTE: the FIFO storage is only three words and rd_data must read 0 after reset, so it is cleared too.
            for (int i = 0; i < 3; i++) fifo_d[i] <= '0;
`ifdef MEM_READBACK_CHECKSUM_EN
            checksum      <= '0;
`endif
        end else begin
            fifo_v        <= nxt_v;
            fifo_l        <= nxt_l;
            fifo_d        <= nxt_d;
            cap_pend      <= rd_pend;
            cap_pend_last <= rd_pend_last;
            rd_pend       <= 1'b0;
            rd_pend_last  <= 1'b0;
            done          <= 1'b0;
`ifdef MEM_READBACK_CHECKSUM_EN
            if (pop) checksum <= checksum + 32'(rd_data);
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        busy         <= 1'b1;
                        mem_raddr    <= '0;
                        rd_pend      <= 1'b1;
                        rd_pend_last <= (LAST_ADDR == 32'd0);
`ifdef MEM_READBACK_CHECKSUM_EN
                        checksum     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (rd_pend && rd_pend_last) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        mem_raddr    <= mem_raddr + 32'd1;
                        rd_pend      <= 1'b1;
                        rd_pend_last <= (mem_raddr + 32'd1 == LAST_ADDR);
                    end
                end
                DRAIN: begin
                    if (pop && fifo_l[0]) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        mem_raddr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
